// File: rtl/mod_arith_pkg.sv
// Shared modular-arithmetic definitions for the interleaved multiplier/divider pair.
// Contents:
//   state_e      - sequencer states IDLE, LOAD, STEP
//   SizemDefault - default operand/modulus width
//   mod_sub      - (x >= y) ? x - y : x + m - y
//   mod_half     - x / 2 mod m for odd m (x even ? x >> 1 : (x + m) >> 1)
// The helpers work on a wide word so any operand width up to MaxW-2 bits fits without
// overflow; callers zero-extend their operands and keep the low bits of the result.
package mod_arith_pkg;

    localparam int unsigned SizemDefault = 8;
    localparam int unsigned MaxW         = 32;

    typedef logic [MaxW-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STEP
    } state_e;

    function automatic word_t mod_sub(input word_t x, input word_t y, input word_t m);
        return (x >= y) ? (x - y) : (x + m - y);
    endfunction

    function automatic word_t mod_half(input word_t x, input word_t m);
        return x[0] ? ((x + m) >> 1) : (x >> 1);
    endfunction

endpackage

// File: rtl/moddiv_step.sv
// Combinational single reduction step of the binary extended Euclidean divider.
// Ports:
//   u_i, v_i     - current u, v
//   x1_i, x2_i   - current x1, x2 (one extra bit of headroom, always < M)
//   m_i          - modulus
//   u_o..x2_o    - values after one halving/subtraction action
//   u_is1_o      - u == 1 (x1 is the result)
//   v_is1_o      - v == 1 (x2 is the result)
//   zero_o       - u or v is zero (operands not coprime)
// Terminal conditions are only flagged here; the caller decides whether to apply the step.
module moddiv_step
    import mod_arith_pkg::*;
#(
    parameter int unsigned SIZEM = SizemDefault
) (
    input  logic [SIZEM-1:0] u_i,
    input  logic [SIZEM-1:0] v_i,
    input  logic [SIZEM:0]   x1_i,
    input  logic [SIZEM:0]   x2_i,
    input  logic [SIZEM-1:0] m_i,
    output logic [SIZEM-1:0] u_o,
    output logic [SIZEM-1:0] v_o,
    output logic [SIZEM:0]   x1_o,
    output logic [SIZEM:0]   x2_o,
    output logic             u_is1_o,
    output logic             v_is1_o,
    output logic             zero_o
);

    word_t x1_w, x2_w, m_w;
    word_t half1, half2, sub12, sub21;

    assign x1_w  = word_t'(x1_i);
    assign x2_w  = word_t'(x2_i);
    assign m_w   = word_t'(m_i);
    assign half1 = mod_half(x1_w, m_w);
    assign half2 = mod_half(x2_w, m_w);
    assign sub12 = mod_sub(x1_w, x2_w, m_w);
    assign sub21 = mod_sub(x2_w, x1_w, m_w);

    // Results are < M, so the upper bits of the wide words are always zero.
    logic unused_hi;
    assign unused_hi = ^{half1[MaxW-1:SIZEM+1], half2[MaxW-1:SIZEM+1],
                         sub12[MaxW-1:SIZEM+1], sub21[MaxW-1:SIZEM+1]};

    assign u_is1_o = (u_i == SIZEM'(1));
    assign v_is1_o = (v_i == SIZEM'(1));
    assign zero_o  = (u_i == '0) || (v_i == '0);

    always_comb begin
        u_o  = u_i;
        v_o  = v_i;
        x1_o = x1_i;
        x2_o = x2_i;
        if (!u_i[0]) begin
            u_o  = u_i >> 1;
            x1_o = half1[SIZEM:0];
        end else if (!v_i[0]) begin
            v_o  = v_i >> 1;
            x2_o = half2[SIZEM:0];
        end else if (u_i >= v_i) begin
            u_o  = u_i - v_i;
            x1_o = sub12[SIZEM:0];
        end else begin
            v_o  = v_i - u_i;
            x2_o = sub21[SIZEM:0];
        end
    end

endmodule

// File: rtl/interleaved_moddiv.sv
// Bit-serial modular divider: Q = a * d^-1 mod M, one binary extended Euclidean step per clock.
// Ports:
//   clk, rst   - clock (rising edge), asynchronous active-high reset
//   start      - begin (or restart) an operation; a, d, M captured in this cycle
//   a, d, M    - dividend, divisor, odd modulus >= 3
//   Q          - quotient, held until the next successful completion
//   done       - one-cycle pulse when Q/err are valid
//   err        - 1 = no result (invalid operands, gcd(d,M) != 1, or step timeout)
//   busy       - high from the cycle after start until done
//   cycles     - STEP-cycle count of the last completed operation
//                (only when MODDIV_CYCLE_COUNT_EN is defined)
module interleaved_moddiv
    import mod_arith_pkg::*;
#(
    parameter int unsigned SIZEM = SizemDefault,
    parameter int unsigned CNTW  = $clog2(4 * SIZEM + 3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SIZEM-1:0] a,
    input  logic [SIZEM-1:0] d,
    input  logic [SIZEM-1:0] M,
    output logic [SIZEM-1:0] Q,
    output logic             done,
    output logic             err,
    output logic             busy
`ifdef MODDIV_CYCLE_COUNT_EN
    ,
    output logic [CNTW-1:0]  cycles
`endif
);

    // The counter reaching 4*SIZEM+2 aborts with err; compare before the increment.
    localparam logic [CNTW-1:0] TmoLast = CNTW'(4 * SIZEM + 1);

    state_e           state_q;
    logic [SIZEM-1:0] u_q, v_q, m_q, q_q;
    logic [SIZEM:0]   x1_q, x2_q;
    logic [CNTW-1:0]  cnt_q;
    logic             done_q, err_q, busy_q;
`ifdef MODDIV_CYCLE_COUNT_EN
    logic [CNTW-1:0]  cycles_q;
`endif

    logic [SIZEM-1:0] u_d, v_d;
    logic [SIZEM:0]   x1_d, x2_d;
    logic             u_is1, v_is1, zero;
    logic             load_bad;
    logic [CNTW-1:0]  cnt_d;

    moddiv_step #(
        .SIZEM (SIZEM)
    ) u_step (
        .u_i     (u_q),
        .v_i     (v_q),
        .x1_i    (x1_q),
        .x2_i    (x2_q),
        .m_i     (m_q),
        .u_o     (u_d),
        .v_o     (v_d),
        .x1_o    (x1_d),
        .x2_o    (x2_d),
        .u_is1_o (u_is1),
        .v_is1_o (v_is1),
        .zero_o  (zero)
    );

    // u holds d and x1 holds a during LOAD.
    assign load_bad = !m_q[0] || (m_q < SIZEM'(3)) || (u_q >= m_q) || (x1_q >= {1'b0, m_q});
    assign cnt_d    = cnt_q + CNTW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            u_q      <= '0;
            v_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            q_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MODDIV_CYCLE_COUNT_EN
            cycles_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: ;
                LOAD: begin
                    if (load_bad) begin
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
`ifdef MODDIV_CYCLE_COUNT_EN
                        cycles_q <= '0;
`endif
                    end else begin
                        state_q <= STEP;
                    end
                end
                STEP: begin
                    cnt_q <= cnt_d;
                    if (u_is1 || v_is1 || zero || (cnt_q == TmoLast)) begin
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
`ifdef MODDIV_CYCLE_COUNT_EN
                        cycles_q <= cnt_d;
`endif
                        if (u_is1) begin
                            q_q   <= x1_q[SIZEM-1:0];
                            err_q <= 1'b0;
                        end else if (v_is1) begin
                            q_q   <= x2_q[SIZEM-1:0];
                            err_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        u_q  <= u_d;
                        v_q  <= v_d;
                        x1_q <= x1_d;
                        x2_q <= x2_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A new start overrides any in-flight operation; a done set above still pulses.
            if (start) begin
                state_q <= LOAD;
                u_q     <= d;
                v_q     <= M;
                x1_q    <= {1'b0, a};
                x2_q    <= '0;
                m_q     <= M;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end
        end
    end

    assign Q    = q_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = busy_q;
`ifdef MODDIV_CYCLE_COUNT_EN
    assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_interleaved_moddiv.sv
module tb_interleaved_moddiv;

    localparam int SIZEM  = 8;
    localparam int CNTW   = $clog2(4 * SIZEM + 3);
    localparam int LatMax = 4 * SIZEM + 3;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic [SIZEM-1:0] a     = '0;
    logic [SIZEM-1:0] d     = '0;
    logic [SIZEM-1:0] m     = '0;
    logic [SIZEM-1:0] q;
    logic             done, err, busy;
`ifdef MODDIV_CYCLE_COUNT_EN
    logic [CNTW-1:0]  cycles;
`endif

    interleaved_moddiv #(
        .SIZEM (SIZEM)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .d     (d),
        .M     (m),
        .Q     (q),
        .done  (done),
        .err   (err),
        .busy  (busy)
`ifdef MODDIV_CYCLE_COUNT_EN
        ,
        .cycles(cycles)
`endif
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; during cycle k (after edge k) it reads k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int q;      // expected Q (when chk_q)
        int err;
        int chk_q;
        int prod;   // check Q*d mod M == a instead of a fixed Q
        int a;
        int d;
        int m;
        int t0;     // cycle in which start was asserted
        int lmin;
        int lmax;
    } exp_t;

    typedef struct {
        int a;
        int d;
        int m;
        int q;
        int err;
        int chk_q;
        int lat;
    } vec_t;

    exp_t exp_q[$];
    int   nchk = 0;
    int   nerr = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Assert start for one cycle; operands are scrambled afterwards to prove capture.
    task automatic issue(input int av, input int dv, input int mv, output int t0);
        @(posedge clk);
        #1;
        a     = SIZEM'(av);
        d     = SIZEM'(dv);
        m     = SIZEM'(mv);
        start = 1'b1;
        t0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = SIZEM'($urandom);
        d     = SIZEM'($urandom);
        m     = SIZEM'($urandom);
    endtask

    task automatic push(input int qv, input int ev, input int cq, input int pr, input int av,
                        input int dv, input int mv, input int t0, input int lmin,
                        input int lmax);
        exp_t e;
        e = '{qv, ev, cq, pr, av, dv, mv, t0, lmin, lmax};
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " done_seen"}, done, 1);
        @(posedge clk);
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            check("done_single_cycle", done_prev, 0);
            check("busy_low_with_done", busy, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                int   lat;
                e   = exp_q.pop_front();
                lat = cyc - e.t0;
                check("err", err, e.err);
                if (e.chk_q != 0) check("Q", q, e.q);
                if (e.prod != 0 && err === 1'b0) check("Q*d mod M", (int'(q) * e.d) % e.m, e.a);
                if (e.lmin == e.lmax) check("latency", lat, e.lmin);
                else check("latency_bound", (lat >= e.lmin && lat <= e.lmax), 1);
            end
        end
        done_prev <= done;
    end

    function automatic int gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    initial begin
        vec_t vecs[$];
        int   t0;
        int   t1;

        // Reset state.
        #12;
        check("reset Q", q, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Hand-derived: latency = 2 (start->LOAD->) + number of STEP cycles.
        vecs.push_back('{1, 3, 7, 5, 0, 1, 6});       // 5*3 = 15 = 1 mod 7
        vecs.push_back('{4, 3, 7, 6, 0, 1, 6});       // 6*3 = 18 = 4 mod 7
        vecs.push_back('{1, 2, 251, 126, 0, 1, 4});   // 126*2 = 252 = 1 mod 251
        vecs.push_back('{1, 6, 9, 0, 1, 0, 7});       // gcd 3: u reaches 0 on the 5th step
        vecs.push_back('{1, 0, 7, 0, 1, 0, 3});       // d = 0
        vecs.push_back('{1, 3, 8, 126, 1, 1, 2});     // even M rejected in LOAD, Q kept
        vecs.push_back('{1, 7, 7, 126, 1, 1, 2});     // d >= M
        vecs.push_back('{9, 2, 9, 126, 1, 1, 2});     // a >= M
        vecs.push_back('{0, 0, 1, 126, 1, 1, 2});     // M < 3
        // d = 1: decided in the first STEP cycle (start+2), visible one edge later.
        vecs.push_back('{200, 1, 251, 200, 0, 1, 3});
        vecs.push_back('{0, 5, 7, 0, 0, 1, 5});       // a = 0 -> Q = 0

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].d, vecs[i].m, t0);
            push(vecs[i].q, vecs[i].err, vecs[i].chk_q, 0, vecs[i].a, vecs[i].d, vecs[i].m,
                 t0, vecs[i].lat, vecs[i].lat);
            wait_done($sformatf("vec%0d", i), 60);
        end

        // Abort: second start while the first op is mid-STEP; only the second completes.
        issue(1, 2, 251, t0);
        issue(4, 3, 7, t1);
        check("busy during abort", busy, 1);
        push(6, 0, 1, 0, 4, 3, 7, t1, 6, 6);
        wait_done("abort", 60);
        repeat (10) @(posedge clk);

        // Reset mid-operation: outputs clear at once and no done follows.
        issue(1, 100, 251, t0);
        @(posedge clk);
        #1;
        check("busy before rst", busy, 1);
        rst = 1'b1;
        #1;
        check("rst Q", q, 0);
        check("rst done", done, 0);
        check("rst busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("busy after rst", busy, 0);

        // Random sweep over odd M, coprime d, a < M.
        for (int k = 0; k < 24; k++) begin
            int mv;
            int dv;
            int av;
            mv = 2 * $urandom_range(1, 127) + 1;
            dv = 1;
            for (int tries = 0; tries < 50; tries++) begin
                dv = $urandom_range(1, mv - 1);
                if (gcd(dv, mv) == 1) break;
                dv = 1;
            end
            av = $urandom_range(0, mv - 1);
            issue(av, dv, mv, t0);
            push(0, 0, 0, 1, av, dv, mv, t0, 2, LatMax);
            wait_done($sformatf("rand%0d", k), LatMax + 10);
        end

        repeat (5) @(posedge clk);
        check("scoreboard empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
